obj_renderer: RTL
=================

OBJ_RENDERER -- requirements
Module: obj_renderer

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 4: number of object slots, range 1..8.
REQ-002 SHALL have parameter OBJ_W, default 20: object width in sheet pixels.
REQ-003 SHALL have parameter OBJ_H, default 20: object height in sheet pixels.
REQ-004 SHALL have parameter SRC_Y0, default 80: sheet row where the sprite strip starts.
REQ-005 SHALL have parameter SHEET_W, default 320; parameter SHEET_DEPTH, default 76800.
REQ-006 SHALL have port clk, input, 1: the only clock.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port frame_start, input, 1: one-cycle pulse at the start of vertical blanking.
REQ-009 SHALL have ports h_cnt and v_cnt, input, 10 each: VGA 640x480 scan position.
REQ-010 SHALL have port obj_en, input, NUM_OBJ: a 1 means the object is still to do (draw it).
REQ-011 SHALL have ports obj_x and obj_y, input, NUM_OBJ*9: packed top-left corners in 320x240 space, slot i at [9i+8:9i].
REQ-012 SHALL have port obj_spr, input, NUM_OBJ*3: packed sprite index for each slot.
REQ-013 SHALL have port pixel_addr, output, 17: sprite-sheet address.
REQ-014 SHALL have port is_object, output, 1: the current pixel belongs to an object.
REQ-015 SHALL have port obj_id, output, 3: the winning slot index.

Function
REQ-016 SHALL latch obj_en, obj_x, obj_y and obj_spr into shadow registers only on a clock edge with frame_start=1; the inputs may change freely at all other times.
REQ-017 SHALL compute x = h_cnt>>1 and y = v_cnt>>1.
REQ-018 SHALL treat slot i as hit when all hold: shadow_en[i]=1, obj_x <= x < obj_x+OBJ_W, obj_y <= y < obj_y+OBJ_H.
REQ-019 SHALL compare in 10-bit arithmetic, so objects near x=319 or y=239 clip and do not wrap.
REQ-020 SHALL give the lowest-index hit slot priority.
REQ-021 SHALL compute pixel_addr = ((spr*OBJ_W + x - obj_x) + (SRC_Y0 + y - obj_y)*SHEET_W) mod SHEET_DEPTH.
REQ-022 SHALL run as a 2-stage pipeline: stage 1 registers per-slot hit and offset, stage 2 registers the priority select and address.
REQ-023 SHALL present outputs exactly 2 clk cycles after the h_cnt/v_cnt sample they belong to.
REQ-024 SHALL force is_object=0, obj_id=0 and pixel_addr=0 when no slot hits, or when h_cnt>=640 or v_cnt>=480.
REQ-025 SHALL let pixels already in flight in the pipeline complete using the old shadow values when frame_start coincides with them.

Reset
REQ-026 SHALL drive is_object=0, obj_id=0 and pixel_addr=0 while rst_n=0.
REQ-027 SHALL clear the shadow registers and pipeline registers while rst_n=0.
REQ-028 SHALL draw nothing after reset is released mid-frame until the next frame_start.

Configuration
REQ-029 SHALL compile in the blink feature when OBJ_BLINK_EN is defined, adding input obj_blink[NUM_OBJ-1:0] (latched per REQ-016) and parameter BLINK_SHIFT, default 4.
REQ-030 SHALL, with OBJ_BLINK_EN defined, keep an 8-bit frame counter that increments on each frame_start, wraps 255->0 and resets to 0.
REQ-031 SHALL, with OBJ_BLINK_EN defined, hide a slot with shadow_blink=1 while counter bit BLINK_SHIFT=1.
REQ-032 SHALL, without OBJ_BLINK_EN, have no obj_blink port and no frame counter, and every enabled slot is always visible.

Structure
REQ-033 SHALL place the default parameter values, the GAME state encodings (TITLE=0 through FAIL=8) and the coordinate width (9) in shared package obj_pkg.
REQ-034 SHALL implement one sub-module, obj_hit, instantiated NUM_OBJ times, each doing the per-slot compare and offset.

Verification
REQ-035 SHALL cover: slot0 en=1 at (65,35), spr0; h_cnt=140, v_cnt=80 -> 2 cycles later is_object=1, obj_id=0, pixel_addr=(5+85*320)=27205.
REQ-036 SHALL cover: slots 0 and 1 both at (235,35) -> obj_id=0; then clear en[0] and pulse frame_start -> obj_id=1, with the address offset by spr1*20.
REQ-037 SHALL cover: change obj_x mid-frame without frame_start -> output unchanged until after the next frame_start.
REQ-038 SHALL cover: object at x=310, h_cnt=638 (x=319) -> is_object=1; h_cnt=640 -> is_object=0.
REQ-039 SHALL cover: assert rst_n=0 mid-line -> outputs 0 immediately; after release, no object until frame_start.
REQ-040 SHALL cover, with OBJ_BLINK_EN defined: blink=1, BLINK_SHIFT=0 -> object visible on alternate frames, frame counter wraps 255->0 correctly.

Source files
------------

// File: rtl/obj_pkg.sv
// Shared constants, game-state encodings and the sprite-sheet address helper
// for the object renderer.
package obj_pkg;

  localparam int NUM_OBJ_DEF     = 4;
  localparam int OBJ_W_DEF       = 20;
  localparam int OBJ_H_DEF       = 20;
  localparam int SRC_Y0_DEF      = 80;
  localparam int SHEET_W_DEF     = 320;
  localparam int SHEET_DEPTH_DEF = 76800;
  localparam int BLINK_SHIFT_DEF = 4;

  localparam int COORD_W = 9;
  localparam int CMP_W   = 10;
  localparam int ADDR_W  = 17;
  localparam int ID_W    = 3;
  localparam int SPR_W   = 3;

  typedef enum logic [3:0] {
    TITLE    = 4'd0,
    READY    = 4'd1,
    PLAY     = 4'd2,
    PAUSE    = 4'd3,
    HIT      = 4'd4,
    LEVEL_UP = 4'd5,
    BOSS     = 4'd6,
    WIN      = 4'd7,
    FAIL     = 4'd8
  } game_state_e;

  // Offsets are zero-extended into 32 bits so the folded sum never overflows.
  function automatic logic [ADDR_W-1:0] sheet_addr(
    input logic [SPR_W-1:0] spr,
    input logic [CMP_W-1:0] dx,
    input logic [CMP_W-1:0] dy,
    input int               obj_w,
    input int               src_y0,
    input int               sheet_w,
    input int               sheet_depth
  );
    logic [31:0] sum_s;
    sum_s = 32'(spr) * 32'(obj_w) + 32'(dx)
          + (32'(src_y0) + 32'(dy)) * 32'(sheet_w);
    return ADDR_W'(sum_s % 32'(sheet_depth));
  endfunction

endpackage

// File: rtl/obj_hit.sv
// Per-slot bounding-box test and sheet offset; first pipeline stage of the
// object renderer.
module obj_hit
  import obj_pkg::*;
#(
  parameter int OBJ_W = OBJ_W_DEF,
  parameter int OBJ_H = OBJ_H_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [COORD_W-1:0] obj_x_i,
  input  logic [COORD_W-1:0] obj_y_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [SPR_W-1:0]   spr_i,
  output logic               hit_o,
  output logic [CMP_W-1:0]   dx_o,
  output logic [CMP_W-1:0]   dy_o,
  output logic [SPR_W-1:0]   spr_o
);

  logic             hit_d, hit_q;
  logic [CMP_W-1:0] dx_d, dx_q, dy_d, dy_q;
  logic [SPR_W-1:0] spr_d, spr_q;
  logic [CMP_W-1:0] x_s, y_s, ox_s, oy_s, x_end_s, y_end_s;

  // Widened to 10 bits so a box near the right/bottom edge clips instead of wrapping.
  always_comb begin
    x_s     = {1'b0, x_i};
    y_s     = {1'b0, y_i};
    ox_s    = {1'b0, obj_x_i};
    oy_s    = {1'b0, obj_y_i};
    x_end_s = ox_s + CMP_W'(OBJ_W);
    y_end_s = oy_s + CMP_W'(OBJ_H);
    hit_d   = en_i && (x_s >= ox_s) && (x_s < x_end_s)
                   && (y_s >= oy_s) && (y_s < y_end_s);
    if (hit_d) begin
      dx_d  = x_s - ox_s;
      dy_d  = y_s - oy_s;
      spr_d = spr_i;
    end else begin
      dx_d  = {CMP_W{1'b0}};
      dy_d  = {CMP_W{1'b0}};
      spr_d = {SPR_W{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      dx_q  <= {CMP_W{1'b0}};
      dy_q  <= {CMP_W{1'b0}};
      spr_q <= {SPR_W{1'b0}};
    end else begin
      hit_q <= hit_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      spr_q <= spr_d;
    end
  end

  assign hit_o = hit_q;
  assign dx_o  = dx_q;
  assign dy_o  = dy_q;
  assign spr_o = spr_q;

endmodule

// File: rtl/obj_renderer.sv
// Sprite object overlay for a 640x480 scan drawn at 320x240; two-stage pipeline.
// Optional per-slot blinking is compiled in with OBJ_BLINK_EN.
module obj_renderer
  import obj_pkg::*;
#(
  parameter int NUM_OBJ     = NUM_OBJ_DEF,
  parameter int OBJ_W       = OBJ_W_DEF,
  parameter int OBJ_H       = OBJ_H_DEF,
  parameter int SRC_Y0      = SRC_Y0_DEF,
  parameter int SHEET_W     = SHEET_W_DEF,
  parameter int SHEET_DEPTH = SHEET_DEPTH_DEF
`ifdef OBJ_BLINK_EN
  ,
  parameter int BLINK_SHIFT = BLINK_SHIFT_DEF
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic [9:0]                 h_cnt,
  input  logic [9:0]                 v_cnt,
  input  logic [NUM_OBJ-1:0]         obj_en,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
  input  logic [NUM_OBJ*SPR_W-1:0]   obj_spr,
`ifdef OBJ_BLINK_EN
  input  logic [NUM_OBJ-1:0]         obj_blink,
`endif
  output logic [ADDR_W-1:0]          pixel_addr,
  output logic                       is_object,
  output logic [ID_W-1:0]            obj_id
);

  logic [NUM_OBJ-1:0]         shadow_en_d, shadow_en_q;
  logic [NUM_OBJ*COORD_W-1:0] shadow_x_d, shadow_x_q, shadow_y_d, shadow_y_q;
  logic [NUM_OBJ*SPR_W-1:0]   shadow_spr_d, shadow_spr_q;
  logic [NUM_OBJ-1:0]         vis_s;
  logic                       in_view_s;
  logic [COORD_W-1:0]         x_s, y_s;

  // Object attributes are sampled once per frame so the game logic may update freely.
  always_comb begin
    if (frame_start) begin
      shadow_en_d  = obj_en;
      shadow_x_d   = obj_x;
      shadow_y_d   = obj_y;
      shadow_spr_d = obj_spr;
    end else begin
      shadow_en_d  = shadow_en_q;
      shadow_x_d   = shadow_x_q;
      shadow_y_d   = shadow_y_q;
      shadow_spr_d = shadow_spr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_en_q  <= {NUM_OBJ{1'b0}};
      shadow_x_q   <= {(NUM_OBJ*COORD_W){1'b0}};
      shadow_y_q   <= {(NUM_OBJ*COORD_W){1'b0}};
      shadow_spr_q <= {(NUM_OBJ*SPR_W){1'b0}};
    end else begin
      shadow_en_q  <= shadow_en_d;
      shadow_x_q   <= shadow_x_d;
      shadow_y_q   <= shadow_y_d;
      shadow_spr_q <= shadow_spr_d;
    end
  end

`ifdef OBJ_BLINK_EN
  logic [NUM_OBJ-1:0] shadow_blink_d, shadow_blink_q;
  logic [7:0]         frame_cnt_d, frame_cnt_q;

  always_comb begin
    if (frame_start) begin
      shadow_blink_d = obj_blink;
      frame_cnt_d    = frame_cnt_q + 8'd1;
    end else begin
      shadow_blink_d = shadow_blink_q;
      frame_cnt_d    = frame_cnt_q;
    end
    vis_s = shadow_en_q & ~(shadow_blink_q & {NUM_OBJ{frame_cnt_q[BLINK_SHIFT]}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_blink_q <= {NUM_OBJ{1'b0}};
      frame_cnt_q    <= 8'd0;
    end else begin
      shadow_blink_q <= shadow_blink_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end
`else
  always_comb begin
    vis_s = shadow_en_q;
  end
`endif

  always_comb begin
    in_view_s = (h_cnt < 10'd640) && (v_cnt < 10'd480);
    x_s       = h_cnt[9:1];
    y_s       = v_cnt[9:1];
  end

  logic [NUM_OBJ-1:0] hit_s;
  logic [CMP_W-1:0]   dx_s  [NUM_OBJ];
  logic [CMP_W-1:0]   dy_s  [NUM_OBJ];
  logic [SPR_W-1:0]   spr_s [NUM_OBJ];

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_slot
    obj_hit #(
      .OBJ_W (OBJ_W),
      .OBJ_H (OBJ_H)
    ) u_hit (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (vis_s[g] & in_view_s),
      .obj_x_i (shadow_x_q[g*COORD_W +: COORD_W]),
      .obj_y_i (shadow_y_q[g*COORD_W +: COORD_W]),
      .x_i     (x_s),
      .y_i     (y_s),
      .spr_i   (shadow_spr_q[g*SPR_W +: SPR_W]),
      .hit_o   (hit_s[g]),
      .dx_o    (dx_s[g]),
      .dy_o    (dy_s[g]),
      .spr_o   (spr_s[g])
    );
  end

  logic [ID_W-1:0]   sel_id_s;
  logic [CMP_W-1:0]  sel_dx_s, sel_dy_s;
  logic [SPR_W-1:0]  sel_spr_s;
  logic              is_object_d, is_object_q;
  logic [ID_W-1:0]   obj_id_d, obj_id_q;
  logic [ADDR_W-1:0] pixel_addr_d, pixel_addr_q;

  // Scanning from the top slot down lets the lowest hit index overwrite the rest.
  always_comb begin
    sel_id_s  = {ID_W{1'b0}};
    sel_dx_s  = {CMP_W{1'b0}};
    sel_dy_s  = {CMP_W{1'b0}};
    sel_spr_s = {SPR_W{1'b0}};
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      sel_id_s  = hit_s[i] ? ID_W'(i) : sel_id_s;
      sel_dx_s  = hit_s[i] ? dx_s[i]  : sel_dx_s;
      sel_dy_s  = hit_s[i] ? dy_s[i]  : sel_dy_s;
      sel_spr_s = hit_s[i] ? spr_s[i] : sel_spr_s;
    end
    is_object_d = |hit_s;
    if (is_object_d) begin
      obj_id_d     = sel_id_s;
      pixel_addr_d = sheet_addr(sel_spr_s, sel_dx_s, sel_dy_s,
                                OBJ_W, SRC_Y0, SHEET_W, SHEET_DEPTH);
    end else begin
      obj_id_d     = {ID_W{1'b0}};
      pixel_addr_d = {ADDR_W{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_object_q  <= 1'b0;
      obj_id_q     <= {ID_W{1'b0}};
      pixel_addr_q <= {ADDR_W{1'b0}};
    end else begin
      is_object_q  <= is_object_d;
      obj_id_q     <= obj_id_d;
      pixel_addr_q <= pixel_addr_d;
    end
  end

  assign is_object  = is_object_q;
  assign obj_id     = obj_id_q;
  assign pixel_addr = pixel_addr_q;

endmodule
